// File: rtl/tx_sta_axil_regs.sv
// AXI4-Lite register file for the TX block: NUM_REGS read/write control words,
// exported as a flat bus with a one-cycle strobe per register write.
module tx_sta_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                     s00_axi_aclk,
  input  logic                                     s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
  input  logic [2:0]                               s00_axi_awprot,
  input  logic                                     s00_axi_awvalid,
  output logic                                     s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
  input  logic                                     s00_axi_wvalid,
  output logic                                     s00_axi_wready,
  output logic [1:0]                               s00_axi_bresp,
  output logic                                     s00_axi_bvalid,
  input  logic                                     s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
  input  logic [2:0]                               s00_axi_arprot,
  input  logic                                     s00_axi_arvalid,
  output logic                                     s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
  output logic [1:0]                               s00_axi_rresp,
  output logic                                     s00_axi_rvalid,
  input  logic                                     s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]                      reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NUM_REGS_W  = NUM_REGS[IDX_W:0];
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  logic [DW-1:0]       regs [NUM_REGS];
  logic                ready_en;
  logic                aw_latched;
  logic                w_latched;
  logic [IDX_W-1:0]    aw_idx;
  logic [DW-1:0]       w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic                aw_in_range;
  logic                ar_in_range;
  logic [IDX_W-1:0]    ar_idx;
  logic [DW-1:0]       rd_word;
  logic [NUM_REGS-1:0] wr_sel;
  logic                unused_inputs;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_REGS_W;
  endfunction

  // Readies stay low during reset and come up one edge after it is released.
  assign s00_axi_awready = ready_en && !aw_latched && !s00_axi_bvalid;
  assign s00_axi_wready  = ready_en && !w_latched && !s00_axi_bvalid;
  assign s00_axi_arready = ready_en && !s00_axi_rvalid;

  assign aw_hs       = s00_axi_awvalid && s00_axi_awready;
  assign w_hs        = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs       = s00_axi_arvalid && s00_axi_arready;
  assign commit      = aw_latched && w_latched && !s00_axi_bvalid;
  assign aw_in_range = in_range(aw_idx);
  assign ar_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_in_range = in_range(ar_idx);

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_sel  = '0;
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (commit && aw_in_range && (|w_strb) && aw_idx == IDX_W'(k)) wr_sel[k] = 1'b1;
      if (ar_idx == IDX_W'(k)) rd_word = regs[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ready_en       <= 1'b0;
      aw_latched     <= 1'b0;
      aw_idx         <= '0;
      w_latched      <= 1'b0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
      reg_wr_pulse   <= '0;
    end else begin
      ready_en     <= 1'b1;
      reg_wr_pulse <= wr_sel;
      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_idx     <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        w_data    <= s00_axi_wdata;
        w_strb    <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_latched     <= 1'b0;
        w_latched      <= 1'b0;
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the register array is a handful of flops that software expects to read as zero
  // after reset, so it is reset like any other state rather than treated as RAM.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_sel[k]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // A read sampled on a commit edge sees the pre-write value.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= ar_in_range ? rd_word : '0;
      s00_axi_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[DW*k +: DW] = regs[k];
  end

endmodule

// File: tb/tb_tx_sta_axil_regs.sv
// Self-checking bench: two instances (4 and 3 registers) share one AXI4-Lite
// stimulus stream and are compared against an array model of the register file.
module tb_tx_sta_axil_regs;

  localparam int AW = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;

  logic          awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic [1:0]    bresp_a, rresp_a;
  logic [31:0]   rdata_a;
  logic [127:0]  reg_out_a;
  logic [3:0]    pulse_a;

  logic          awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]    bresp_b, rresp_b;
  logic [31:0]   rdata_b;
  logic [95:0]   reg_out_b;
  logic [2:0]    pulse_b;

  logic [31:0] ma [4];
  logic [31:0] mb [3];
  int asserts_run = 0;
  int fails       = 0;

  tx_sta_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(4)) dut_a (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready_a),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready_a),
    .s00_axi_bresp(bresp_a), .s00_axi_bvalid(bvalid_a), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready_a),
    .s00_axi_rdata(rdata_a), .s00_axi_rresp(rresp_a), .s00_axi_rvalid(rvalid_a), .s00_axi_rready(rready),
    .reg_out(reg_out_a), .reg_wr_pulse(pulse_a)
  );

  tx_sta_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(3)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready_b),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready_b),
    .s00_axi_bresp(bresp_b), .s00_axi_bvalid(bvalid_b), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready_b),
    .s00_axi_rdata(rdata_b), .s00_axi_rresp(rresp_b), .s00_axi_rvalid(rvalid_b), .s00_axi_rready(rready),
    .reg_out(reg_out_b), .reg_wr_pulse(pulse_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    asserts_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] pack_a();
    return {ma[3], ma[2], ma[1], ma[0]};
  endfunction

  function automatic logic [127:0] pack_b();
    return {32'h0, mb[2], mb[1], mb[0]};
  endfunction

  task automatic clear_models();
    for (int k = 0; k < 4; k++) ma[k] = '0;
    for (int k = 0; k < 3; k++) mb[k] = '0;
  endtask

  // Write with AW offered after aw_d cycles and W after w_d cycles; bready held high.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_d, input int w_d);
    int idx, last_hs, seen_at;
    bit aw_done, w_done, seen;
    logic [3:0] pa;
    logic [2:0] pb;
    idx = int'(addr) / 4;
    pa  = (idx < 4 && strb != 0) ? 4'(1 << idx) : 4'b0;
    pb  = (idx < 3 && strb != 0) ? 3'(1 << idx) : 3'b0;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
    aw_done = 0; w_done = 0; seen = 0; last_hs = 0; seen_at = 0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (bvalid_a) begin
        seen = 1; seen_at = n;
      end else begin
        awvalid = !aw_done && n >= aw_d;
        wvalid  = !w_done && n >= w_d;
        if (awvalid && awready_a) begin aw_done = 1; last_hs = n; end
        if (wvalid && wready_a)   begin w_done = 1;  last_hs = n; end
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_seen", seen, 1'b1);
    check("b_latency", seen_at - last_hs, 2);
    check("bvalid_b", bvalid_b, 1'b1);
    check("bresp_a", bresp_a, (idx < 4) ? OKAY : SLVERR);
    check("bresp_b", bresp_b, (idx < 3) ? OKAY : SLVERR);
    check("pulse_a", pulse_a, pa);
    check("pulse_b", pulse_b, pb);
    if (idx < 4) ma[idx] = merge(ma[idx], data, strb);
    if (idx < 3) mb[idx] = merge(mb[idx], data, strb);
    @(negedge clk);
    check("bvalid_drop", bvalid_a, 1'b0);
    check("pulse_a_once", pulse_a, 4'b0);
    check("pulse_b_once", pulse_b, 3'b0);
    check("reg_out_a", reg_out_a, pack_a());
    check("reg_out_b", reg_out_b, pack_b());
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    int idx;
    bit hs;
    logic [31:0] ea, eb;
    idx = int'(addr) / 4;
    ea  = (idx < 4) ? ma[idx] : 32'h0;
    eb  = (idx < 3) ? mb[idx] : 32'h0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1; hs = 0;
    for (int n = 0; n < 64 && !hs; n++) begin
      if (arready_a) hs = 1;
      else @(negedge clk);
    end
    check("ar_handshake", hs, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_a", rvalid_a, 1'b1);
    check("rvalid_b", rvalid_b, 1'b1);
    check("rdata_a", rdata_a, ea);
    check("rresp_a", rresp_a, (idx < 4) ? OKAY : SLVERR);
    check("rdata_b", rdata_b, eb);
    check("rresp_b", rresp_b, (idx < 3) ? OKAY : SLVERR);
    @(negedge clk);
    check("rvalid_drop", rvalid_a, 1'b0);
    check("arready_back", arready_a, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; wdata = '0; wstrb = '0;
    clear_models();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", awready_a, 1'b0);
    check("rst_wready", wready_a, 1'b0);
    check("rst_arready", arready_a, 1'b0);
    check("rst_bvalid", bvalid_a, 1'b0);
    check("rst_rvalid", rvalid_a, 1'b0);
    check("rst_bresp_rresp", {bresp_a, rresp_a}, 4'b0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_reg_out", reg_out_a, 128'h0);
    check("rst_pulse", pulse_a, 4'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {awready_a, wready_a, arready_a}, 3'b111);

    // Basic write/read of every register
    for (int k = 0; k < 4; k++) do_write(4'(4 * k), 32'(k + 1), 4'hF, 0, 0);
    for (int k = 0; k < 4; k++) do_read(4'(4 * k));
    check("reg_out_1234", reg_out_a, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW
    do_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
    check("reg2_deadbeef", reg_out_a[95:64], 32'hDEADBEEF);

    // Byte-lane strobes
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(4'h5, 32'h12345678, 4'b0101, 0, 1);
    check("reg1_strobed", reg_out_a[63:32], 32'hFF34FF78);

    // wstrb of zero leaves the register untouched and raises no strobe
    do_write(4'h0, 32'h77777777, 4'h0, 1, 0);
    check("reg0_unchanged", reg_out_a[31:0], 32'h1);

    // Out of range on the 3-register instance
    do_write(4'hC, 32'hAA, 4'hF, 0, 0);
    do_read(4'hC);

    // bready held low for 5 cycles; a second AW waits for the B handshake
    awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; bready = 1'b0; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    ma[0] = 32'h55; mb[0] = 32'h55;
    check("hold_pulse", pulse_a, 4'b0001);
    awaddr = 4'h4; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", bvalid_a, 1'b1);
      check("hold_bresp", bresp_a, OKAY);
      check("hold_ready", {awready_a, wready_a}, 2'b00);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("hold_b_done", bvalid_a, 1'b0);
    check("hold_aw_ready", awready_a, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    check("hold_aw_latched", awready_a, 1'b0);
    wdata = 32'h66; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    check("hold_second_b", bvalid_a, 1'b1);
    ma[1] = 32'h66; mb[1] = 32'h66;
    @(negedge clk);
    check("hold_reg_out", reg_out_a, pack_a());

    // Read sampled on the commit edge of a write to the same register
    awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("same_edge_rvalid", rvalid_a, 1'b1);
    check("same_edge_old", rdata_a, ma[1]);
    check("same_edge_bvalid", bvalid_a, 1'b1);
    ma[1] = 32'hCAFEF00D; mb[1] = 32'hCAFEF00D;
    @(negedge clk);
    check("same_edge_new", reg_out_a, pack_a());

    // Randomized mix of reads and writes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      else
        do_read(4'($urandom));
    end
    check("rand_reg_out_b", reg_out_b, pack_b());

    // Reset with both a B and an R response pending
    bready = 1'b0; rready = 1'b0;
    awaddr = 4'h8; wdata = 32'h12121212; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_pending", {bvalid_a, rvalid_a}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valids", {bvalid_a, rvalid_a, bvalid_b, rvalid_b}, 4'b0);
    check("mid_rst_reg_out_a", reg_out_a, 128'h0);
    check("mid_rst_reg_out_b", reg_out_b, 96'h0);
    check("mid_rst_ready", {awready_a, arready_a}, 2'b00);
    clear_models();
    @(negedge clk);
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    do_read(4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_run, fails);
    $finish;
  end

endmodule
